// File: rtl/uart_frame_pkg.sv
// Shared constants, status codes and parser state encoding for the UART command-frame parser.
package uart_frame_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hAA;
  localparam logic [7:0] RESP_FLAG = 8'h80;

  localparam logic [7:0] CMD_SET_LED = 8'h01;
  localparam logic [7:0] CMD_GET_LED = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CHK = 8'h01;
  localparam logic [7:0] ST_BAD_LEN = 8'h02;
  localparam logic [7:0] ST_BAD_CMD = 8'h03;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_RESP
  } state_t;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SET_LED) || (cmd == CMD_GET_LED);
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// RX/TX FIFO handshake bundle between the frame parser (master) and the UART FIFOs (slave).
interface uart_frame_parser_if;
  logic       Empty_Sig;
  logic       Read_Req_Sig;
  logic [7:0] FIFO_Read_Data;
  logic       Full_Sig;
  logic       Write_Req_Sig;
  logic [7:0] FIFO_Write_Data;

  modport master (
    input  Empty_Sig, FIFO_Read_Data, Full_Sig,
    output Read_Req_Sig, Write_Req_Sig, FIFO_Write_Data
  );

  modport slave (
    output Empty_Sig, FIFO_Read_Data, Full_Sig,
    input  Read_Req_Sig, Write_Req_Sig, FIFO_Write_Data
  );
endinterface

// File: rtl/uart_resp_tx.sv
// Serializes the 4-byte response frame into the TX FIFO, stalling on full; done pulses with the last write.
module uart_resp_tx
  import uart_frame_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       full,
  input  logic [7:0] cmd,
  input  logic [7:0] status,
  input  logic [3:0] led,
  output logic       wr_req,
  output logic [7:0] wr_data,
  output logic       done
);

  logic [1:0] idx_q, idx_d;
  logic [7:0] cur_byte;

  always_comb begin
    idx_d   = idx_q;
    done    = 1'b0;
    wr_req  = en && !full;
    case (idx_q)
      2'd0:    cur_byte = HDR_BYTE;
      2'd1:    cur_byte = cmd | RESP_FLAG;
      2'd2:    cur_byte = status;
      default: cur_byte = {4'b0, led};
    endcase
    wr_data = wr_req ? cur_byte : 8'h00;
    if (!en) begin
      idx_d = '0;
    end else if (wr_req) begin
      idx_d = idx_q + 2'd1;
      done  = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// UART command-frame parser: hunts AA/CMD/LEN/payload/CHK frames, drives the LED register, answers via TX FIFO.
// Optional macro UART_FRAME_STATS_EN enables saturating good/bad frame counters.
//
// state  | meaning
// HUNT   | discard bytes until header 0xAA
// CMD    | capture command byte, seed checksum
// LEN    | capture length, reject oversize length
// DATA   | accumulate payload checksum, first byte is the argument
// CHK    | compare checksum, execute, pulse Frame_Ok/Frame_Err
// RESP   | emit 4-byte response, no RX reads
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                CLK,
  input  logic                RST,
  uart_frame_parser_if.master bus,
  output logic [3:0]          LED_OUT,
  output logic                Frame_Ok,
  output logic                Frame_Err,
  output logic [15:0]         Good_Cnt,
  output logic [15:0]         Bad_Cnt
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic          rd_pend_q, rd_pend_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, chk_q, chk_d, status_q, status_d;
  logic [7:0]    data_idx_q, data_idx_d;
  logic [3:0]    arg_q, arg_d, led_q, led_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rd_req, rd_valid, tx_done;
  logic [7:0]    rx_byte;

  assign rx_byte  = bus.FIFO_Read_Data;
  assign rd_valid = rd_pend_q;
  // Reads stop during RESP so the response is never interleaved with a new frame.
  assign rd_req   = !bus.Empty_Sig && !rd_pend_q && (state_q != S_RESP) && !RST;

  always_comb begin
    state_d    = state_q;
    rd_pend_d  = rd_req;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    status_d   = status_q;
    data_idx_d = data_idx_q;
    arg_d      = arg_q;
    led_d      = led_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    tmo_d      = '0;
    case (state_q)
      S_HUNT: if (rd_valid && rx_byte == HDR_BYTE) state_d = S_CMD;
      S_CMD: if (rd_valid) begin
        cmd_d   = rx_byte;
        chk_d   = rx_byte;
        state_d = S_LEN;
      end
      S_LEN: if (rd_valid) begin
        len_d      = rx_byte;
        chk_d      = chk_q ^ rx_byte;
        data_idx_d = '0;
        if (rx_byte > MAX_LEN_B) begin
          status_d = ST_BAD_LEN;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else if (rx_byte == 8'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (rd_valid) begin
        chk_d      = chk_q ^ rx_byte;
        data_idx_d = data_idx_q + 8'd1;
        if (data_idx_q == 8'd0) arg_d = rx_byte[3:0];
        if (data_idx_q == len_q - 8'd1) state_d = S_CHK;
      end
      S_CHK: if (rd_valid) begin
        if (chk_q != rx_byte)                          status_d = ST_BAD_CHK;
        else if (!cmd_known(cmd_q))                    status_d = ST_BAD_CMD;
        else if (cmd_q == CMD_SET_LED && len_q == 8'd0) status_d = ST_BAD_LEN;
        else                                           status_d = ST_OK;
        if (status_d == ST_OK) begin
          ok_d = 1'b1;
          if (cmd_q == CMD_SET_LED) led_d = arg_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: if (tx_done) state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
    // An arriving byte always beats an expiring gap timer.
    if (state_q inside {S_CMD, S_LEN, S_DATA, S_CHK} && !rd_valid) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = S_HUNT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_HUNT;
      rd_pend_q  <= 1'b0;
      cmd_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      status_q   <= '0;
      data_idx_q <= '0;
      arg_q      <= '0;
      led_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      status_q   <= status_d;
      data_idx_q <= data_idx_d;
      arg_q      <= arg_d;
      led_q      <= led_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  uart_resp_tx u_resp_tx (
    .CLK     (CLK),
    .RST     (RST),
    .en      ((state_q == S_RESP) && !RST),
    .full    (bus.Full_Sig),
    .cmd     (cmd_q),
    .status  (status_q),
    .led     (led_q),
    .wr_req  (bus.Write_Req_Sig),
    .wr_data (bus.FIFO_Write_Data),
    .done    (tx_done)
  );

  assign bus.Read_Req_Sig = rd_req;
  assign LED_OUT          = led_q;
  assign Frame_Ok         = ok_q;
  assign Frame_Err        = err_q;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] good_q, good_d, bad_q, bad_d;

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (ok_d && good_q != 16'hFFFF) good_d = good_q + 16'd1;
    if (err_d && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign Good_Cnt = good_q;
  assign Bad_Cnt  = bad_q;
`else
  assign Good_Cnt = '0;
  assign Bad_Cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames in, expected TX bytes and frame events queued and checked by a monitor.
module tb_uart_frame_parser;

  typedef struct packed {
    logic       ok;
    logic [3:0] led;
  } ev_t;

`ifdef UART_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  LED_OUT;
  logic        Frame_Ok, Frame_Err;
  logic [15:0] Good_Cnt, Bad_Cnt;

  always #5 CLK = ~CLK;

  uart_frame_parser_if bus();

  uart_frame_parser #(.MAX_LEN(8), .TIMEOUT_CYCLES(100)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .LED_OUT   (LED_OUT),
    .Frame_Ok  (Frame_Ok),
    .Frame_Err (Frame_Err),
    .Good_Cnt  (Good_Cnt),
    .Bad_Cnt   (Bad_Cnt)
  );

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  ev_t        exp_ev[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_good = 0;
  int         exp_bad = 0;
  logic       chk_reset = 1'b0;
  logic       quiet = 1'b0;
  logic       chk_final = 1'b0;
  logic [7:0] want_b;
  ev_t        want_e;

  // RX FIFO model: data appears the cycle after the read strobe.
  always @(posedge CLK) begin
    if (RST) begin
      bus.Empty_Sig      <= 1'b1;
      bus.FIFO_Read_Data <= 8'h00;
    end else begin
      if (bus.Read_Req_Sig) bus.FIFO_Read_Data <= rx_q.pop_front();
      bus.Empty_Sig <= (rx_q.size() == 0);
    end
  end

  // Monitor: all comparisons happen here, away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      exp_good = 0;
      exp_bad  = 0;
    end
    if (bus.Write_Req_Sig) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got=%02h want=none", bus.FIFO_Write_Data);
      end else begin
        want_b = exp_tx.pop_front();
        if (bus.FIFO_Write_Data !== want_b) begin
          errors++;
          $display("FAIL tx_byte got=%02h want=%02h", bus.FIFO_Write_Data, want_b);
        end
      end
    end
    if (Frame_Ok || Frame_Err) begin
      checks++;
      if (exp_ev.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected got ok=%0b err=%0b led=%h want=none", Frame_Ok, Frame_Err, LED_OUT);
      end else begin
        want_e = exp_ev.pop_front();
        if ({Frame_Ok, Frame_Err, LED_OUT} !== {want_e.ok, !want_e.ok, want_e.led}) begin
          errors++;
          $display("FAIL frame_event got ok=%0b err=%0b led=%h want ok=%0b err=%0b led=%h",
                   Frame_Ok, Frame_Err, LED_OUT, want_e.ok, !want_e.ok, want_e.led);
        end
        if (want_e.ok) exp_good++;
        else           exp_bad++;
      end
    end
    if (quiet) begin
      checks++;
      if (bus.Read_Req_Sig !== 1'b0 || bus.Write_Req_Sig !== 1'b0) begin
        errors++;
        $display("FAIL resp_stall got rd=%0b wr=%0b want rd=0 wr=0", bus.Read_Req_Sig, bus.Write_Req_Sig);
      end
    end
    if (chk_reset) begin
      checks++;
      if ({LED_OUT, Frame_Ok, Frame_Err, bus.Read_Req_Sig, bus.Write_Req_Sig, bus.FIFO_Write_Data,
           Good_Cnt, Bad_Cnt} !== '0) begin
        errors++;
        $display("FAIL reset_state got led=%h ok=%0b err=%0b rd=%0b wr=%0b wd=%02h good=%0d bad=%0d want all 0",
                 LED_OUT, Frame_Ok, Frame_Err, bus.Read_Req_Sig, bus.Write_Req_Sig,
                 bus.FIFO_Write_Data, Good_Cnt, Bad_Cnt);
      end
    end
    if (chk_final) begin
      checks++;
      if (exp_tx.size() != 0 || exp_ev.size() != 0) begin
        errors++;
        $display("FAIL leftover got tx_pending=%0d ev_pending=%0d want 0 0", exp_tx.size(), exp_ev.size());
      end
      checks++;
      if (Good_Cnt !== (STATS ? 16'(exp_good) : 16'h0) || Bad_Cnt !== (STATS ? 16'(exp_bad) : 16'h0)) begin
        errors++;
        $display("FAIL stats got good=%0d bad=%0d want good=%0d bad=%0d", Good_Cnt, Bad_Cnt,
                 STATS ? exp_good : 0, STATS ? exp_bad : 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) rx_q.push_back(b[i]);
  endtask

  task automatic expect_tx(input logic [7:0] b[$]);
    foreach (b[i]) exp_tx.push_back(b[i]);
  endtask

  task automatic expect_ev(input logic ok, input logic [3:0] led);
    ev_t e;
    e.ok  = ok;
    e.led = led;
    exp_ev.push_back(e);
  endtask

  // Bounded wait: leftovers are reported by the final check.
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_tx.size() == 0 && exp_ev.size() == 0 && rx_q.size() == 0) break;
    end
    repeat (6) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    chk_reset = 1'b1;
    tick();
    chk_reset = 1'b0;
  endtask

  initial begin
    bus.Full_Sig = 1'b0;
    do_reset();

    // SET_LED 5
    expect_ev(1'b1, 4'h5);
    expect_tx('{8'hAA, 8'h81, 8'h00, 8'h05});
    send('{8'hAA, 8'h01, 8'h01, 8'h05, 8'h05});
    drain(200);

    do_reset();

    // bad checksum, LED stays 0
    expect_ev(1'b0, 4'h0);
    expect_tx('{8'hAA, 8'h81, 8'h01, 8'h00});
    send('{8'hAA, 8'h01, 8'h01, 8'h05, 8'h06});
    drain(200);

    // leading garbage then unknown command
    expect_ev(1'b0, 4'h0);
    expect_tx('{8'hAA, 8'h87, 8'h03, 8'h00});
    send('{8'h13, 8'hAA, 8'h07, 8'h00, 8'h07});
    drain(200);

    // oversize length answered without payload
    expect_ev(1'b0, 4'h0);
    expect_tx('{8'hAA, 8'h81, 8'h02, 8'h00});
    send('{8'hAA, 8'h01, 8'h09});
    drain(200);

    // SET_LED with two payload bytes, only the first is the argument
    expect_ev(1'b1, 4'hA);
    expect_tx('{8'hAA, 8'h81, 8'h00, 8'h0A});
    send('{8'hAA, 8'h01, 8'h02, 8'h0A, 8'h33, 8'h3A});
    drain(200);

    // inter-byte timeout, no response
    expect_ev(1'b0, 4'hA);
    send('{8'hAA, 8'h01});
    drain(400);

    expect_ev(1'b1, 4'hA);
    expect_tx('{8'hAA, 8'h82, 8'h00, 8'h0A});
    send('{8'hAA, 8'h02, 8'h00, 8'h02});
    drain(200);

    // TX full during GET_LED response, next frame already waiting in RX
    bus.Full_Sig = 1'b1;
    expect_ev(1'b1, 4'hA);
    expect_tx('{8'hAA, 8'h82, 8'h00, 8'h0A});
    expect_ev(1'b1, 4'hA);
    expect_tx('{8'hAA, 8'h82, 8'h00, 8'h0A});
    send('{8'hAA, 8'h02, 8'h01, 8'h77, 8'h74, 8'hAA, 8'h02, 8'h00, 8'h02});
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_ev.size() == 1) break;
    end
    quiet = 1'b1;
    repeat (20) tick();
    quiet = 1'b0;
    bus.Full_Sig = 1'b0;
    drain(300);

    chk_final = 1'b1;
    tick();
    chk_final = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Command-frame parser that sits directly downstream of the UART RX FIFO and upstream of the UART TX FIFO.
- Pops bytes from the RX FIFO and hunts for framed commands: 0xAA, CMD, LEN, payload[LEN], CHK.
- Validates each frame, executes it against a 4-bit LED register, and pushes a 4-byte response frame into the TX FIFO.

Parameters:
MAX_LEN, 8, largest accepted LEN value (1..255)
TIMEOUT_CYCLES, 500000, maximum inter-byte gap in CLK cycles before a partial frame is dropped

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
Empty_Sig  input  1  RX FIFO empty
Read_Req_Sig  output  1  RX FIFO read strobe, 1-cycle pulse
FIFO_Read_Data  input  8  RX FIFO data, valid the cycle after Read_Req_Sig
Full_Sig  input  1  TX FIFO full
Write_Req_Sig  output  1  TX FIFO write strobe, 1-cycle pulse
FIFO_Write_Data  output  8  TX FIFO data, valid with Write_Req_Sig
LED_OUT  output  4  LED register
Frame_Ok  output  1  1-cycle pulse when a valid frame is executed
Frame_Err  output  1  1-cycle pulse on checksum, length, command or timeout error
Good_Cnt  output  16  good-frame count (FRAME_STATS_EN only, else 0)
Bad_Cnt  output  16  bad-frame count (FRAME_STATS_EN only, else 0)

Behaviour:
- Reset: all outputs 0, state HUNT, no outstanding read, timeout counter 0.
- Fetch:
  - Read_Req_Sig pulses only when !Empty_Sig, no read is outstanding, and state is not RESP.
  - The byte is captured exactly 1 cycle later (rd_valid). Maximum rate is one byte per 2 cycles.
- States: HUNT -> CMD -> LEN -> DATA -> CHK -> RESP -> HUNT.
  - HUNT: discard any byte that is not 0xAA; 0xAA -> CMD.
  - CMD: latch cmd; chk = cmd.
  - LEN:
    - latch len; chk ^= len.
    - len > MAX_LEN -> status 0x02, RESP immediately (remaining bytes are treated as HUNT garbage).
    - len == 0 -> CHK.
    - otherwise -> DATA.
  - DATA: chk ^= byte; the first payload byte is latched as arg; after len bytes -> CHK.
  - CHK, status priority:
    - chk != byte -> 0x01
    - else cmd unknown -> 0x03
    - else cmd 0x01 with len==0 -> 0x02
    - else 0x00
  - Execution on status 0x00:
    - cmd 0x01 (SET_LED): LED_OUT <= arg[3:0] in the same cycle the CHK byte is evaluated.
    - cmd 0x02 (GET_LED): no state change; payload is ignored.
  - Frame_Ok or Frame_Err pulses in that same cycle; then -> RESP.
  - RESP: write 0xAA, cmd|0x80, status, {4'b0,LED_OUT} (post-update value).
    - Each byte is written only when !Full_Sig.
    - While Full_Sig is high the byte is held and Write_Req_Sig stays 0.
    - After the 4th write -> HUNT.
- Timeout: counter runs in CMD/LEN/DATA/CHK and clears on every rd_valid.
  - Reaching TIMEOUT_CYCLES-1 -> Frame_Err pulse, HUNT, no response.
  - If rd_valid coincides with expiry, the byte wins and the counter clears.
- Counter is held at 0 in HUNT and RESP.
- RST mid-frame or mid-response aborts immediately; no further writes; LED_OUT returns to 0.

Optional Feature:
UART_FRAME_STATS_EN
- Defined: Good_Cnt increments with each Frame_Ok, Bad_Cnt with each Frame_Err. Both saturate at 0xFFFF and clear on RST.
- Undefined: both ports tied to 0; no counter logic is synthesized.

Decomposition:
- Package uart_frame_pkg holds:
  - header constant 8'hAA and response flag 8'h80
  - command codes CMD_SET_LED=8'h01, CMD_GET_LED=8'h02
  - status codes ST_OK=0x00, ST_BAD_CHK=0x01, ST_BAD_LEN=0x02, ST_BAD_CMD=0x03
  - state encoding
- One sub-module: uart_resp_tx. It serializes the 4 response bytes against Full_Sig and returns a done pulse.

Test Plan:
- Stream AA 01 01 05 05 -> LED_OUT=0x5, one Frame_Ok, TX writes AA 81 00 05.
- Stream AA 01 01 05 06 -> Frame_Err, LED_OUT unchanged (0x0), TX writes AA 81 01 00.
- Stream 13 AA 07 00 07 -> leading 0x13 discarded, Frame_Err, TX writes AA 87 03 00.
- MAX_LEN=8, stream AA 01 09 -> response AA 81 02 00 issued right after the LEN byte, with no waiting for payload.
- TIMEOUT_CYCLES=100, stream AA 01 then idle 100 cycles -> Frame_Err, no TX writes. Next AA 02 00 02 -> TX AA 82 00 LED.
- Full_Sig high for 20 cycles during RESP of a valid GET_LED -> Write_Req_Sig stays 0, no bytes lost, all 4 bytes in order afterwards, Read_Req_Sig stays 0 throughout RESP.
